// File: rtl/safety_check_multi_if.sv
// Bundles the per-channel current samples, clear strobe and fault outputs of
// safety_check_multi. The master drives the samples; the slave reports the faults.
interface safety_check_multi_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16,
   parameter int TCNT_W = 8
);
   logic [NUM_CH*DATA_W-1:0] cur_fb;
   logic [NUM_CH*DATA_W-1:0] cur_cmd;
   logic [NUM_CH-1:0]        ch_enable;
   logic                     clear_wen;
   logic [NUM_CH-1:0]        clear_mask;
   logic [NUM_CH-1:0]        amp_disable;
   logic                     any_fault;
   logic [NUM_CH*TCNT_W-1:0] trip_count;

   modport master (
      output cur_fb, cur_cmd, ch_enable, clear_wen, clear_mask,
      input  amp_disable, any_fault, trip_count
   );

   modport slave (
      input  cur_fb, cur_cmd, ch_enable, clear_wen, clear_mask,
      output amp_disable, any_fault, trip_count
   );
endinterface

// File: rtl/safety_check_multi.sv
// N-channel overcurrent check: |fb| > (|cmd| << RATIO_SHIFT) + MARGIN must persist
// PERSIST clocks before latching a per-channel amplifier disable.
module safety_check_multi #(
   parameter int                 NUM_CH      = 4,
   parameter int                 DATA_W      = 16,
   parameter int                 RATIO_SHIFT = 1,
   parameter logic [DATA_W-1:0]  MARGIN      = 'h0200,
   parameter int                 PERSIST     = 8,
   parameter int                 TCNT_W      = 8
) (
   input logic               sysclk,
   input logic               reset,
   safety_check_multi_if.slave bus
);

   localparam int                PW       = $clog2(PERSIST + 1);
   localparam int                LIM_W    = DATA_W + RATIO_SHIFT + 1;
   localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MAX_POS  = ~SIGN_BIT;
   localparam logic [PW-1:0]     P_SAT    = PW'(PERSIST);
   localparam logic [TCNT_W-1:0] T_SAT    = '1;

   logic [NUM_CH-1:0][DATA_W-1:0] fb_mag_q, fb_mag_d;
   logic [NUM_CH-1:0][DATA_W-1:0] cmd_mag_q, cmd_mag_d;
   logic [NUM_CH-1:0]             over_q, over_d;
   logic [NUM_CH-1:0][PW-1:0]     pcnt_q, pcnt_d;
   logic [NUM_CH-1:0]             amp_q, amp_d;
   logic                          any_q, any_d;
   logic [NUM_CH-1:0][TCNT_W-1:0] tcnt_q, tcnt_d;

   // Offset binary to magnitude; the most-negative code clamps to the positive maximum.
   function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] s;
      s = x ^ SIGN_BIT;
      if (!s[DATA_W-1])     return s;
      else if (s == SIGN_BIT) return MAX_POS;
      else                  return -s;
   endfunction

   always_comb begin
      logic [LIM_W-1:0] limit;
      logic             trip;
      logic             clr;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      fb_mag_d  = '0;
      cmd_mag_d = '0;
      over_d    = '0;
      pcnt_d    = '0;
      amp_d     = '0;
      tcnt_d    = tcnt_q;
      limit     = '0;
      trip      = 1'b0;
      clr       = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         fb_mag_d[i]  = mag_f(bus.cur_fb[i*DATA_W +: DATA_W]);
         cmd_mag_d[i] = mag_f(bus.cur_cmd[i*DATA_W +: DATA_W]);

         // Limit is widened by RATIO_SHIFT+1 bits so the shift and add cannot wrap.
         limit     = (LIM_W'(cmd_mag_q[i]) << RATIO_SHIFT) + LIM_W'(MARGIN);
         over_d[i] = LIM_W'(fb_mag_q[i]) > limit;

         if (!bus.ch_enable[i])    pcnt_d[i] = '0;
         else if (over_q[i])       pcnt_d[i] = (pcnt_q[i] == P_SAT) ? P_SAT : pcnt_q[i] + PW'(1);
         else                      pcnt_d[i] = '0;

         trip     = (pcnt_d[i] == P_SAT) && (pcnt_q[i] != P_SAT);
         clr      = bus.clear_wen & bus.clear_mask[i];
         amp_d[i] = (pcnt_d[i] == P_SAT) | (amp_q[i] & ~clr);

         if (clr)                            tcnt_d[i] = trip ? TCNT_W'(1) : '0;
         else if (trip && tcnt_q[i] != T_SAT) tcnt_d[i] = tcnt_q[i] + TCNT_W'(1);
      end
      any_d = |amp_d;
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sysclk) begin
      if (!reset) begin
         fb_mag_q  <= '0;
         cmd_mag_q <= '0;
         over_q    <= '0;
         pcnt_q    <= '0;
         amp_q     <= '0;
         any_q     <= 1'b0;
         tcnt_q    <= '0;
      end else begin
         fb_mag_q  <= fb_mag_d;
         cmd_mag_q <= cmd_mag_d;
         over_q    <= over_d;
         pcnt_q    <= pcnt_d;
         amp_q     <= amp_d;
         any_q     <= any_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign bus.amp_disable = amp_q;
   assign bus.any_fault   = any_q;
   assign bus.trip_count  = tcnt_q;

endmodule
